// File: rtl/fifo_rr_arbiter.sv
// Packet-locking round-robin arbiter that drives a shared FIFO push port and
// keeps the occupancy count/full/empty flags for the consumer pop side.
module fifo_rr_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 8,
   parameter int  DEPTH      = 8,
   parameter int  CNT_WIDTH  = 4,
   localparam int IDW        = $clog2(NUM_REQ)
) (
   input  logic                          CLK,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          fifo_push,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   input  logic                          pop_req,
   output logic                          fifo_pop,
   output logic [CNT_WIDTH-1:0]          count,
   output logic                          empty,
   output logic                          full,
   output logic [IDW-1:0]                owner
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       owner_q, owner_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic                 cand_vld;
   logic [IDW-1:0]       cand_id;
   logic [IDW-1:0]       idx;
   logic [IDW-1:0]       sel;
   logic                 accept;

   assign full  = (count_q == CNT_WIDTH'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign owner = owner_q;

   // Descending scan so the lowest offset from rr_ptr is the last (winning) match.
   always_comb begin
      cand_vld = 1'b0;
      cand_id  = rr_ptr_q;
      idx      = rr_ptr_q;
      if (state_q == LOCKED) begin
         cand_vld = req[owner_q];
         cand_id  = owner_q;
      end else begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = rr_ptr_q + IDW'(i);
            if (req[idx]) begin
               cand_vld = 1'b1;
               cand_id  = idx;
            end
         end
      end
   end

   assign accept    = cand_vld & ~full & ~rst;
   assign fifo_push = accept;
   assign fifo_pop  = pop_req & ~empty & ~rst;
   assign sel       = accept ? cand_id : owner_q;
   assign fifo_data = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      gnt = '0;
      if (accept) begin
         gnt[cand_id] = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      count_d  = count_q + CNT_WIDTH'(fifo_push) - CNT_WIDTH'(fifo_pop);
      if (accept) begin
         owner_d = cand_id;
         if (req_last[cand_id]) begin
            state_d  = IDLE;
            rr_ptr_d = cand_id + IDW'(1);
         end else begin
            state_d  = LOCKED;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
      end
   end

   a_gnt_onehot:  assert property (@(posedge CLK) disable iff (rst) $onehot0(gnt));
   a_push_gnt:    assert property (@(posedge CLK) disable iff (rst) fifo_push == (|gnt));
   a_no_gnt_full: assert property (@(posedge CLK) disable iff (rst) !(full && (|gnt)));
   a_no_pop_empt: assert property (@(posedge CLK) disable iff (rst) !(empty && fifo_pop));

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Vector table plus fairness sweep for fifo_rr_arbiter; pushed beats are
// tracked in a scoreboard queue and matched against fifo_data on each push.
module tb_fifo_rr_arbiter;
   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic              CLK = 1'b0;
   logic              rst;
   logic [NR-1:0]     req;
   logic [NR-1:0]     req_last;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     gnt;
   logic              fifo_push;
   logic [DW-1:0]     fifo_data;
   logic              pop_req;
   logic              fifo_pop;
   logic [CW-1:0]     count;
   logic              empty;
   logic              full;
   logic [1:0]        owner;

   fifo_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .CLK(CLK), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
      .gnt(gnt), .fifo_push(fifo_push), .fifo_data(fifo_data), .pop_req(pop_req),
      .fifo_pop(fifo_pop), .count(count), .empty(empty), .full(full), .owner(owner)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       r;
      logic [3:0] rq;
      logic [3:0] lst;
      logic       pop;
      logic [3:0] gnt;
      logic       fpop;
      int         cnt;
      int         own;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(string name, int idx, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] lst, logic pop,
                               logic [3:0] g, logic fp, int c, int o);
      vec_t v;
      v.r = r; v.rq = rq; v.lst = lst; v.pop = pop;
      v.gnt = g; v.fpop = fp; v.cnt = c; v.own = o;
      return v;
   endfunction

   // Drive at posedge+1, check combinational outputs at posedge+4,
   // then registered outputs at the following posedge+1.
   task automatic step(vec_t v, int idx);
      logic [7:0] exp_d;
      rst      = v.r;
      req      = v.rq;
      req_last = v.lst;
      pop_req  = v.pop;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'($urandom);
      for (int i = 0; i < NR; i++)
         if (v.gnt[i]) exp_q.push_back(req_data[i*DW +: DW]);
      #3;
      chk("gnt", idx, int'(gnt), int'(v.gnt));
      chk("fifo_pop", idx, int'(fifo_pop), int'(v.fpop));
      if (fifo_push) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL push_unexpected @%0d: got push expected none", idx);
         end else begin
            exp_d = exp_q.pop_front();
            chk("fifo_data", idx, int'(fifo_data), int'(exp_d));
         end
      end
      @(posedge CLK);
      #1;
      chk("count", idx, int'(count), v.cnt);
      chk("empty", idx, int'(empty), int'(v.cnt == 0));
      chk("full", idx, int'(full), int'(v.cnt == DEPTH));
      chk("owner", idx, int'(owner), v.own);
   endtask

   initial begin
      rst = 1'b1; req = '0; req_last = '0; req_data = '0; pop_req = 1'b0;

      // reset: outputs gated while rst is high
      vecs.push_back(mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0));
      vecs.push_back(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0));
      // fill with rotating single-beat grants
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'(1 << (k % 4)), 0, k + 1, k % 4));
      vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 8, 3));
      // full: pop without grant, then coincident push/pop
      vecs.push_back(mk(0, 4'h1, 4'h1, 1, 4'h0, 1, 7, 3));
      vecs.push_back(mk(0, 4'h1, 4'h1, 1, 4'h1, 1, 7, 0));
      for (int k = 0; k < 7; k++)
         vecs.push_back(mk(0, 4'h0, 4'h0, 1, 4'h0, 1, 6 - k, 0));
      // producer 2 locks for 3 beats while producer 0 waits
      vecs.push_back(mk(0, 4'h5, 4'h1, 0, 4'h4, 0, 1, 2));
      vecs.push_back(mk(0, 4'h5, 4'h1, 0, 4'h4, 0, 2, 2));
      vecs.push_back(mk(0, 4'h5, 4'h5, 0, 4'h4, 0, 3, 2));
      vecs.push_back(mk(0, 4'h5, 4'h5, 0, 4'h1, 0, 4, 0));
      // drain, then pops on empty are dropped
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 4'h0, 4'h0, 1, 4'h0, 1, 3 - k, 0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h2, 4'h2, 0, 4'h2, 0, 1, 1));
      vecs.push_back(mk(0, 4'h0, 4'h0, 1, 4'h0, 1, 0, 1));
      // mid-packet reset drops the lock and the pointer
      vecs.push_back(mk(0, 4'h2, 4'h0, 0, 4'h2, 0, 1, 1));
      vecs.push_back(mk(1, 4'h2, 4'h0, 0, 4'h0, 0, 0, 0));
      vecs.push_back(mk(0, 4'h3, 4'h3, 0, 4'h1, 0, 1, 0));
      vecs.push_back(mk(0, 4'h3, 4'h3, 0, 4'h2, 0, 2, 1));
      // locked owner idles: others stay blocked
      vecs.push_back(mk(0, 4'h8, 4'h0, 0, 4'h8, 0, 3, 3));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(0, 4'h2, 4'h2, 0, 4'h0, 0, 3, 3));
      vecs.push_back(mk(0, 4'hA, 4'hA, 0, 4'h8, 0, 4, 3));
      vecs.push_back(mk(0, 4'h2, 4'h2, 0, 4'h2, 0, 5, 1));

      @(posedge CLK);
      #1;
      foreach (vecs[i]) step(vecs[i], i);

      // fairness sweep with continuous push and pop: occupancy holds at 1
      step(mk(1, 4'h0, 4'h0, 0, 4'h0, 0, 0, 0), 1000);
      for (int k = 0; k < 12; k++)
         step(mk(0, 4'hF, 4'hF, 1, 4'(1 << (k % 4)), logic'(k != 0), 1, k % 4), 1001 + k);

      chk("scoreboard_left", 2000, exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout @0: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Packet-aware round-robin arbiter and occupancy controller that shares one FIFO (DEPTH entries, DATA_WIDTH bits) between NUM_REQ producers.
- Selects one producer per cycle and drives the FIFO push and data.
- Holds the grant for a producer until its packet's last beat has been pushed.
- Gates consumer pops and maintains the count, full and empty flags that the FIFO itself does not produce.
- Sits between the producer ports and the FIFO, alongside the data-integrity scoreboard, which observes the same push and pop.

Parameters:
NUM_REQ, 4, number of producer ports (power of 2, at least 2)
DATA_WIDTH, 8, beat width in bits
DEPTH, 8, FIFO entry count (power of 2)
CNT_WIDTH, 4, occupancy counter width, equal to log2(DEPTH)+1

Ports:
CLK  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-producer beat valid
req_last  input  NUM_REQ  per-producer last beat of packet; qualified by req
req_data  input  NUM_REQ*DATA_WIDTH  producer i beat at bits [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  NUM_REQ  one-hot; beat from producer i is accepted this cycle
fifo_push  output  1  FIFO push strobe
fifo_data  output  DATA_WIDTH  data of the granted producer
pop_req  input  1  consumer wants a beat
fifo_pop  output  1  FIFO pop strobe
count  output  CNT_WIDTH  registered occupancy, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
owner  output  log2(NUM_REQ)  current or last granted producer id

Behaviour:
Reset:
- While rst is high: gnt=0, fifo_push=0, fifo_pop=0 combinationally.
- On the next edge: count=0, empty=1, full=0, owner=0, rr_ptr=0, state=IDLE.
- Reset asserted mid-packet abandons the lock; no partial-packet cleanup. Data already in the FIFO is discarded by the FIFO's own reset.

State machine (states IDLE, LOCKED):
- IDLE: candidate = first i with req[i]=1, searching from rr_ptr upward modulo NUM_REQ.
- LOCKED: candidate = owner, only when req[owner]=1. Other requests are ignored even if owner is idle.
- Accept: gnt[candidate]=1 and fifo_push=1 when a candidate exists and full=0. This is combinational, zero latency.
- fifo_data = req_data slice of the candidate. When no push, fifo_data is don't-care and is driven from owner.

Transitions and pointer updates on an accepted beat from producer k:
- If req_last[k]=1: state goes to IDLE, rr_ptr = k+1 mod NUM_REQ.
- Otherwise: state goes to LOCKED.
- In both cases owner=k.
- A single-beat packet (last on the first beat) never enters LOCKED.

Full:
- No grant while full=1, even if a pop occurs in the same cycle.
- Push is evaluated on registered count only.
- A locked owner waits while full and keeps the lock.

Pop:
- fifo_pop = pop_req & ~empty. A pop when empty is dropped silently with no error flag.

Count:
- count_next = count + fifo_push − fifo_pop.
- Simultaneous push and pop leave count unchanged.
- Count never exceeds DEPTH and never underflows, guaranteed by the gating above.
- full and empty are decoded from registered count.

Fairness:
- With every producer continuously requesting single-beat packets, grants rotate 0,1,2,3,0,…
- Each producer waits at most (NUM_REQ−1) packets.

Invariants (assertions):
- gnt is one-hot or zero.
- fifo_push == |gnt.
- No gnt while full.
- No fifo_pop while empty.

Test Plan:
1. Reset, then req=4'b1111 and req_last=4'b1111 for 8 cycles, pop_req=0 → gnt = 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; count goes 1 through 8; full=1 after the 8th edge.
2. From full: req=4'b0001, pop_req=1 for one cycle → no gnt, fifo_pop=1, count 8→7; next cycle gnt=0001 and count stays 7 when a push and pop coincide.
3. Locking: producer 2 sends 3 beats with last on the 3rd while req[0]=1 throughout → gnt=0100 ×3, then gnt=0001; rr_ptr=3 after the packet; owner=2 during the packet.
4. Empty pop: count=0, pop_req=1 for 3 cycles → fifo_pop=0 and count=0 throughout; then one push followed by a pop gives count 0→1→0 and empty toggles 1→0→1.
5. Mid-packet reset: producer 1 locked after beat 1 of 4, rst high for 1 cycle → gnt=0 in that cycle; afterwards state=IDLE, rr_ptr=0, count=0, and req=4'b0011 yields gnt=0001 first.
6. Lock stall: producer 3 locked and req[3] drops for 5 cycles while req[1]=1 → no gnt for those 5 cycles; producer 3 resumes and its last beat completes, then gnt=0010.
